// File: rtl/fsm_4_seq_pkg.sv
// Shared types and constants for the fsm_4 operand sequencer: state encoding,
// default widths, finish/timeout constants and the expected-result function.
package fsm_4_seq_pkg;

    localparam int SEQ_DATA_W     = 32;
    localparam int SEQ_RES_W      = 36;
    localparam int SEQ_LAST_STATE = 9;
    localparam int SEQ_TIMEOUT    = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_OUT
    } seq_state_e;

    // Value fsm_4 reports on its result port once it reaches the finish state.
    function automatic logic [SEQ_RES_W-1:0] fsm_4_expected(
        input logic [SEQ_DATA_W-1:0] a,
        input logic [SEQ_DATA_W-1:0] b
    );
        logic [SEQ_RES_W-1:0] ax;
        logic [SEQ_RES_W-1:0] bx;
        ax = SEQ_RES_W'(a);
        bx = SEQ_RES_W'(b);
        return ((((ax + bx) << 2) + bx) >> 1) + ((bx >> 1) + (ax << 2));
    endfunction

endpackage

// File: rtl/fsm_4_operand_fifo.sv
// Synchronous FIFO holding {A,B} operand pairs; pointers carry one extra wrap
// bit so full and empty are told apart without a separate count.
module fsm_4_operand_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; empty pointers already
    // guarantee nothing stale is ever read, and it keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fsm_4_operand_sequencer.sv
// Feeds queued operand pairs to fsm_4 one at a time, restarting it through its
// active-low reset, and returns each result (or a timeout) on a valid/ready port.
module fsm_4_operand_sequencer
    import fsm_4_seq_pkg::*;
#(
    parameter int DATA_W     = SEQ_DATA_W,
    parameter int RES_W      = SEQ_RES_W,
    parameter int DEPTH      = 4,
    parameter int LAST_STATE = SEQ_LAST_STATE,
    parameter int TIMEOUT    = SEQ_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              fsm_reset,
    output logic [DATA_W-1:0] fsm_a,
    output logic [DATA_W-1:0] fsm_b,
    input  logic [3:0]        fsm_state,
    input  logic [RES_W-1:0]  fsm_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic              out_timeout,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*DATA_W-1:0]   fifo_rdata;

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic                  valid_q, valid_d;
    logic [RES_W-1:0]      res_q, res_d;
    logic                  to_q, to_d;

    fsm_4_operand_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && !fifo_full),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = valid_q;
        res_d    = res_q;
        to_d     = to_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    {a_d, b_d} = fifo_rdata;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Finish wins over timeout when both land in the same cycle.
                if (fsm_state == 4'(LAST_STATE)) begin
                    res_d   = fsm_result;
                    to_d    = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    to_d    = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        {a_d, b_d} = fifo_rdata;
                        state_d    = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            to_q    <= to_d;
        end
    end

    // fsm_4 is released only while RUN, so an async reset parks it at once.
    assign fsm_reset   = (state_q == ST_RUN);
    assign fsm_a       = a_q;
    assign fsm_b       = b_q;
    assign in_ready    = !fifo_full;
    assign out_valid   = valid_q;
    assign out_result  = res_q;
    assign out_timeout = to_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
